// File: rtl/widget2_sched_pkg.sv
// Shared types and sizing helpers for the widget2 scheduler.
// State encoding plus width functions used for port and counter sizing.
package widget2_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Width of the transfer counter, which must reach WIDTH+LAT.
  function automatic int cnt_w(input int width, input int lat);
    return $clog2(width + lat + 1);
  endfunction

endpackage

// File: rtl/widget2_rr_arb.sv
// Combinational round-robin arbiter for the widget2 scheduler.
// Grants the first asserted request strictly after ptr, wrapping to 0.
module widget2_rr_arb
  import widget2_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic found;

  // Two passes: indices above ptr first, then wrap to indices at or below ptr.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (ID_W'(i) > ptr)) begin
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (ID_W'(i) <= ptr)) begin
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/widget2_sched.sv
// Round-robin scheduler sharing one widget2 serial datapath among NREQ requesters.
// A granted word is shifted LSB-first into the widget, the widget's output stream
// is collected into rsp_data, and the result is returned tagged with the requester id.
// Optional feature macro: WIDGET2_SCHED_PRIO_EN (requester 0 wins whenever it is valid,
// without moving the round-robin pointer).
module widget2_sched
  import widget2_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int LAT   = 1,
  localparam int ID_W  = id_w(NREQ),
  localparam int CNT_W = cnt_w(WIDTH, LAT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  w_data_in,
  input  logic                  w_data_out,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH + LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  shreg;
  logic              arb_en;
  logic              prio_hit;
  logic [NREQ-1:0]   arb_req;
  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [WIDTH-1:0]  gnt_word;

`ifdef WIDGET2_SCHED_PRIO_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign prio_hit = req_valid[0];
  assign arb_req  = {req_valid[NREQ-1:1], 1'b0};
`else
  assign prio_hit = 1'b0;
  assign arb_req  = req_valid;
`endif

  widget2_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (arb_req),
    .ptr    (ptr),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Final grant: priority override on top of the rotating arbiter.
  always_comb begin
    gnt    = arb_gnt;
    gnt_id = arb_id;
    if (arb_en && prio_hit) begin
      gnt    = NREQ'(1);
      gnt_id = '0;
    end
  end

  // Select the granted requester's word (gnt is one-hot or zero).
  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_word = gnt_word | req_data[i*WIDTH +: WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = XFER;
      XFER:    if (cnt == CNT_LAST) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; a grant is suppressed during reset so no request is consumed and then lost.
  always_comb begin
    arb_en    = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        arb_en = !rst;
        busy   = 1'b0;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign req_ready = gnt;

  // Datapath: latch grant, shift the word out LSB-first, capture the widget stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= ID_W'(NREQ - 1);
      cnt       <= '0;
      shreg     <= '0;
      w_data_in <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            rsp_id    <= gnt_id;
            if (!prio_hit) ptr <= gnt_id;
            w_data_in <= gnt_word[0];
            shreg     <= gnt_word >> 1;
            cnt       <= '0;
          end
        end
        XFER: begin
          // shreg drains to zero, so w_data_in is 0 once all WIDTH bits are out.
          w_data_in <= shreg[0];
          shreg     <= shreg >> 1;
          cnt       <= cnt + CNT_W'(1);
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CNT_W'(i + LAT)) rsp_data[i] <= w_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_widget2_sched.sv
// Self-checking bench for widget2_sched (NREQ=4, WIDTH=8, LAT=1).
// Widget is modelled as a registered inverter; a scoreboard holds expected
// responses per requester and a monitor checks grants, timing and responses.
module tb_widget2_sched;
  import widget2_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LAT   = 1;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  w_data_in;
  logic                  w_data_out = 1'b0;
  logic                  busy;

  widget2_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .w_data_in  (w_data_in),
    .w_data_out (w_data_out)
    ,.busy      (busy)
  );

  always #5 clk = ~clk;

  // Widget model: one-cycle registered inverter.
  always @(posedge clk) w_data_out <= ~w_data_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus and scoreboard state.
  logic [WIDTH-1:0] stim_q [NREQ][$];
  logic [WIDTH-1:0] exp_q  [NREQ][$];
  int               grant_log[$];
  int               gcyc_log[$];
  logic [WIDTH-1:0] rsp_log[$];
  logic [NREQ-1:0]  withhold = '0;
  bit               hold_en  = 0;
  bit               manual   = 0;
  bit               mon_en   = 1;
  int               rdy_mode = 2;

  // Reference model of the scheduler's visible behaviour.
  bit txn_active = 0;
  int cur_id     = 0;
  int last_id    = NREQ - 1;
  int rsp_due    = 0;
  int idle_from  = 0;

  // Next requester to win: cyclic search starting after the last RR winner.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef WIDGET2_SCHED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
`ifdef WIDGET2_SCHED_PRIO_EN
      if (j != 0 && v[j]) return j;
`else
      if (v[j]) return j;
`endif
    end
    return -1;
  endfunction

  // Monitor: compares DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    int exp_id;
    if (rst) begin
      txn_active = 0;
      last_id    = NREQ - 1;
      idle_from  = 0;
    end else if (mon_en) begin
      check("busy", 32'(busy), 32'(txn_active));
      check("rsp_valid", 32'(rsp_valid), 32'(txn_active && cyc >= rsp_due));
      if (rsp_valid && txn_active && cyc >= rsp_due) begin
        check("rsp_id", 32'(rsp_id), 32'(cur_id));
        if (exp_q[cur_id].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: id %0d data %0h with no expected word", rsp_id, rsp_data);
        end else begin
          check("rsp_data", 32'(rsp_data), 32'(exp_q[cur_id][0]));
          if (rsp_ready) begin
            rsp_log.push_back(rsp_data);
            void'(exp_q[cur_id].pop_front());
            txn_active = 0;
            idle_from  = cyc + 1;
          end
        end
      end
      if (!txn_active && cyc >= idle_from && req_valid != '0) begin
        exp_id = pick(req_valid, last_id);
        check("req_ready_grant", 32'(req_ready), 32'(1) << exp_id);
        txn_active = 1;
        cur_id     = exp_id;
        rsp_due    = cyc + WIDTH + LAT + 1;
`ifdef WIDGET2_SCHED_PRIO_EN
        if (exp_id != 0) last_id = exp_id;
`else
        last_id = exp_id;
`endif
        grant_log.push_back(exp_id);
        gcyc_log.push_back(cyc);
      end else begin
        check("req_ready_idle", 32'(req_ready), 32'(0));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
      end
    end
  end

  task automatic send(input int i, input logic [WIDTH-1:0] w);
    stim_q[i].push_back(w);
    exp_q[i].push_back(~w);
  endtask

  // One clock of stimulus, driven just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (!manual) begin
      withhold = hold_en ? NREQ'($urandom & $urandom) : '0;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (stim_q[i].size() > 0) && !withhold[i];
        req_data[i*WIDTH +: WIDTH] = (stim_q[i].size() > 0) ? stim_q[i][0] : WIDTH'($urandom);
      end
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  endtask

  function automatic bit pending();
    bit p;
    p = txn_active;
    for (int i = 0; i < NREQ; i++) if (stim_q[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    step();
    while (pending() && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(n < budget), 32'(1));
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gcyc_log.delete();
    rsp_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [WIDTH-1:0] w;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'(0));
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset_rsp_id",    32'(rsp_id),    32'(0));
    check("reset_rsp_data",  32'(rsp_data),  32'(0));
    check("reset_w_data_in", 32'(w_data_in), 32'(0));
    check("reset_busy",      32'(busy),      32'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // All four requesters at once: order 0,1,2,3, 11 cycles apart.
    rdy_mode = 0;
    clear_logs();
    send(0, 8'h00); send(1, 8'h11); send(2, 8'h22); send(3, 8'h33);
    wait_drain("drain_all_four", 200);
    check("all4_count", 32'(grant_log.size()), 32'(4));
    if (grant_log.size() == 4 && rsp_log.size() == 4) begin
      logic [WIDTH-1:0] exp_words [4];
      exp_words = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
      for (int k = 0; k < 4; k++) begin
        check("all4_order", 32'(grant_log[k]), 32'(k));
        check("all4_word",  32'(rsp_log[k]),   32'(exp_words[k]));
        if (k > 0) check("all4_spacing", 32'(gcyc_log[k] - gcyc_log[k-1]), 32'(WIDTH + LAT + 2));
      end
    end

    // Single request A5 -> 5A.
    clear_logs();
    send(0, 8'hA5);
    wait_drain("drain_single", 100);
    check("single_count", 32'(rsp_log.size()), 32'(1));
    if (rsp_log.size() == 1) check("single_word", 32'(rsp_log[0]), 32'(8'h5A));

    // req0 and req2 continuously valid with ptr=0: grants alternate 2,0,...
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      send(0, WIDTH'($urandom));
      send(2, WIDTH'($urandom));
    end
    wait_drain("drain_alternate", 300);
    check("alt_count", 32'(grant_log.size()), 32'(6));
    if (grant_log.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
`ifdef WIDGET2_SCHED_PRIO_EN
        check("alt_order", 32'(grant_log[k]), (k < 3) ? 32'(0) : 32'(2));
`else
        check("alt_order", 32'(grant_log[k]), (k % 2 == 0) ? 32'(2) : 32'(0));
`endif
      end
    end

    // Backpressure: hold the response for 20 cycles.
    clear_logs();
    rdy_mode = 2;
    send(1, 8'h96);
    send(3, 8'h0F);
    n = 0;
    step();
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'(1));
    repeat (20) step();
    check("bp_hold_valid", 32'(rsp_valid), 32'(1));
    check("bp_hold_id",    32'(rsp_id),    32'(1));
    check("bp_hold_data",  32'(rsp_data),  32'(8'h69));
    rdy_mode = 0;
    wait_drain("drain_backpressure", 100);
    check("bp_count", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() == 2) begin
      check("bp_second_grant", 32'(grant_log[1]), 32'(3));
      check("bp_regrant_gap",  32'(gcyc_log[1] - gcyc_log[0]), 32'(WIDTH + LAT + 2 + 20 + 1));
    end

    // Reset at cnt=4 of a transfer: aborted, then req0 is re-granted.
    mon_en = 0;
    manual = 1;
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    req_data  = '0;
    req_data[WIDTH-1:0] = 8'h3C;
    rsp_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (req_ready != 4'b0001 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_grant", 32'(req_ready), 32'(4'b0001));
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req_ready", 32'(req_ready), 32'(0));
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_rsp_id",    32'(rsp_id),    32'(0));
    check("midrst_rsp_data",  32'(rsp_data),  32'(0));
    check("midrst_w_data_in", 32'(w_data_in), 32'(0));
    check("midrst_busy",      32'(busy),      32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    send(0, 8'h3C);
    manual = 0;
    mon_en = 1;
    @(negedge clk);
    check("midrst_regrant", 32'(req_ready), 32'(4'b0001));
    wait_drain("drain_after_reset", 100);
    check("midrst_rsp_count", 32'(rsp_log.size()), 32'(1));
    if (rsp_log.size() == 1) check("midrst_word", 32'(rsp_log[0]), 32'(8'hC3));

    // Randomized traffic with withdrawals and random backpressure.
    hold_en  = 1;
    rdy_mode = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = WIDTH'($urandom);
        send(int'($urandom_range(0, NREQ - 1)), w);
      end
      step();
    end
    hold_en  = 0;
    rdy_mode = 0;
    wait_drain("drain_random", 3000);
    for (int i = 0; i < NREQ; i++) check("final_exp_empty", 32'(exp_q[i].size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
